// File: rtl/jb_ul_dfe_car_pkt_framer.sv
// UL carrier packet framer: aligns an antenna-interleaved sample stream to antenna 0,
// packs PKT_GROUPS antenna groups per packet and buffers them in a commit/rollback FIFO.
module jb_ul_dfe_car_pkt_framer #(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int USR_ID_BW  = $clog2(N_ANTENNAS),
  parameter int PKT_GROUPS = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_4x,
  input  logic                          reset_4x,
  input  logic                          enable,
  input  logic                          s_tvalid,
  input  logic [2*PRECISION-1:0]        s_tdata,
  input  logic [USR_ID_BW-1:0]          s_tuser,
  input  logic                          m_tready,
  output logic                          m_tvalid,
  output logic [2*PRECISION-1:0]        m_tdata,
  output logic [USR_ID_BW-1:0]          m_tuser,
  output logic                          m_tlast,
  output logic                          seq_err,
  output logic                          ovf,
  output logic [15:0]                   pkt_cnt,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PKT_BEATS = PKT_GROUPS * N_ANTENNAS;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int EW        = 2*PRECISION + USR_ID_BW + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_BEATS - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DROP} state_t;

  state_t         state;
  logic [AW:0]    wr_ptr, wr_commit, rd_ptr;
  logic [CW-1:0]  beat_cnt;
  logic [EW-1:0]  mem [FIFO_DEPTH];

  logic           has_space, id_ok, last_beat, wr_en, commit, rd_en;
  logic [AW:0]    used, commit_next, rd_next;

  // The expected antenna ID is the low bits of beat_cnt; beat_cnt is held at 0 in SYNC.
  always_comb begin
    used        = wr_ptr - rd_ptr;
    has_space   = (used != DEPTH);
    id_ok       = (s_tuser == beat_cnt[USR_ID_BW-1:0]);
    last_beat   = (beat_cnt == LAST_BEAT);
    wr_en       = enable && s_tvalid && id_ok && has_space &&
                  ((state == SYNC) || (state == ACTIVE));
    commit      = wr_en && last_beat;
    rd_en       = m_tvalid && m_tready;
    commit_next = commit ? (wr_ptr + 1'b1) : wr_commit;
    rd_next     = rd_en ? (rd_ptr + 1'b1) : rd_ptr;
  end

  assign m_tvalid = (rd_ptr != wr_commit);
  assign {m_tlast, m_tuser, m_tdata} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_4x) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {last_beat, s_tuser, s_tdata};
  end

  always_ff @(posedge clk_4x) begin
    if (reset_4x) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      beat_cnt   <= '0;
      seq_err    <= 1'b0;
      ovf        <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      fifo_level <= '0;
    end else begin
      seq_err    <= 1'b0;
      ovf        <= 1'b0;
      rd_ptr     <= rd_next;
      fifo_level <= commit_next - rd_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) begin
        wr_commit <= wr_ptr + 1'b1;
        pkt_cnt   <= pkt_cnt + 16'd1;
      end
      // Dropping enable abandons the open packet; rollback cases never coincide with wr_en.
      if (!enable) begin
        wr_ptr   <= wr_commit;
        beat_cnt <= '0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (s_tvalid && id_ok) begin
              beat_cnt <= CW'(1);
              if (has_space) begin
                state <= ACTIVE;
              end else begin
                ovf      <= 1'b1;
                drop_cnt <= drop_cnt + 16'd1;
                state    <= DROP;
              end
            end
          end
          ACTIVE: begin
            if (s_tvalid) begin
              if (!id_ok) begin
                seq_err  <= 1'b1;
                wr_ptr   <= wr_commit;
                beat_cnt <= '0;
                state    <= SYNC;
              end else begin
                beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
                if (!has_space) begin
                  ovf      <= 1'b1;
                  drop_cnt <= drop_cnt + 16'd1;
                  wr_ptr   <= wr_commit;
                  if (!last_beat) state <= DROP;
                end
              end
            end
          end
          DROP: begin
            if (s_tvalid) begin
              beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
              if (last_beat) state <= ACTIVE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jb_ul_dfe_car_pkt_framer.sv
// Self-checking bench for jb_ul_dfe_car_pkt_framer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based packet model.
module tb_jb_ul_dfe_car_pkt_framer;

  localparam int N     = 4;
  localparam int BEATS = 8;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_SYNC = 1, M_ACTIVE = 2, M_DROP = 3;

  logic        clk_4x = 1'b0;
  logic        reset_4x, enable, s_tvalid, m_tready;
  logic [31:0] s_tdata;
  logic [1:0]  s_tuser;
  logic        m_tvalid, m_tlast, seq_err, ovf;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic [15:0] pkt_cnt, drop_cnt;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  // Reference model state: committed and pending packet beats as queues.
  logic [34:0] fifo_q[$];
  logic [34:0] pend_q[$];
  logic [31:0] out_log[$];
  int          mode = M_IDLE;
  int          pos = 0;
  int          m_pkts = 0;
  int          m_drops = 0;
  bit          exp_seq = 0;
  bit          exp_ovf = 0;

  jb_ul_dfe_car_pkt_framer dut (
    .clk_4x(clk_4x), .reset_4x(reset_4x), .enable(enable),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .seq_err(seq_err), .ovf(ovf),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk_4x = ~clk_4x;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compareOutputs();
    checkOutput("m_tvalid", m_tvalid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) checkOutput("m_beat", {m_tlast, m_tuser, m_tdata}, fifo_q[0]);
    checkOutput("fifo_level", fifo_level, fifo_q.size());
    checkOutput("pkt_cnt", pkt_cnt, 16'(m_pkts));
    checkOutput("drop_cnt", drop_cnt, 16'(m_drops));
    checkOutput("seq_err", seq_err, exp_seq);
    checkOutput("ovf", ovf, exp_ovf);
  endtask

  task automatic modelStep(input logic rst, input logic en, input logic v,
                           input logic [1:0] u, input logic [31:0] d, input logic rdy);
    bit          rd, space;
    logic [34:0] ent;
    exp_seq = 0;
    exp_ovf = 0;
    if (rst) begin
      fifo_q.delete(); pend_q.delete();
      mode = M_IDLE; pos = 0; m_pkts = 0; m_drops = 0;
      return;
    end
    rd    = (fifo_q.size() != 0) && rdy;
    space = (fifo_q.size() + pend_q.size()) < DEPTH;
    ent   = {(pos == BEATS-1), u, d};
    if (!en) begin
      pend_q.delete(); mode = M_IDLE; pos = 0;
    end else if (mode == M_IDLE) begin
      mode = M_SYNC;
    end else if (v) begin
      case (mode)
        M_SYNC: if (u == 2'd0) begin
          pos = 1;
          if (space) begin pend_q.push_back(ent); mode = M_ACTIVE; end
          else begin exp_ovf = 1; m_drops++; mode = M_DROP; end
        end
        M_ACTIVE: begin
          if (u != 2'(pos % N)) begin
            exp_seq = 1; pend_q.delete(); pos = 0; mode = M_SYNC;
          end else if (!space) begin
            exp_ovf = 1; m_drops++; pend_q.delete();
            if (pos == BEATS-1) pos = 0;
            else begin pos++; mode = M_DROP; end
          end else begin
            pend_q.push_back(ent);
            if (pos == BEATS-1) begin
              foreach (pend_q[i]) fifo_q.push_back(pend_q[i]);
              pend_q.delete(); m_pkts++; pos = 0;
            end else pos++;
          end
        end
        default: begin
          if (pos == BEATS-1) begin pos = 0; mode = M_ACTIVE; end
          else pos++;
        end
      endcase
    end
    if (rd) void'(fifo_q.pop_front());
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model, advance both.
  task automatic applyStimulus(input logic rst, input logic en, input logic v,
                               input logic [1:0] u, input logic [31:0] d, input logic rdy);
    @(negedge clk_4x);
    reset_4x = rst; enable = en; s_tvalid = v; s_tuser = u; s_tdata = d; m_tready = rdy;
    #1;
    compareOutputs();
    if (!rst && m_tvalid && m_tready) out_log.push_back(m_tdata);
    modelStep(rst, en, v, u, d, rdy);
    @(posedge clk_4x);
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 2'd0, 32'd0, rdy);
  endtask

  task automatic sendBeats(input int first_id, input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 1, 2'((first_id + i) % N), $urandom, rdy);
  endtask

  task automatic checkIndexPacket(input string tag);
    checkOutput({tag, "_len"}, out_log.size(), 8);
    foreach (out_log[i]) checkOutput(tag, out_log[i], 32'(i + 2));
  endtask

  initial begin
    int   gen_id;
    logic rdy, en, v;
    logic [1:0] u;

    reset_4x = 1; enable = 0; s_tvalid = 0; s_tuser = 0; s_tdata = 0; m_tready = 1;
    repeat (3) @(posedge clk_4x);

    // Alignment: IDs 2,3 are discarded, data 2..9 forms the packet.
    $display("[TB] alignment packet");
    idleCycles(1, 1);
    out_log.delete();
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 2'((i + 2) % N), 32'(i), 1);
    idleCycles(12, 1);
    checkIndexPacket("align_data");
    checkOutput("align_pkt_cnt", pkt_cnt, 16'd1);

    // Sequence error, then a clean packet.
    $display("[TB] sequence error");
    sendBeats(0, 2, 1);
    applyStimulus(0, 1, 1, 2'd3, 32'h33, 1);
    sendBeats(0, BEATS, 1);
    idleCycles(12, 1);

    // Backpressure overflow: two packets fill the FIFO, the third is dropped.
    $display("[TB] overflow");
    sendBeats(0, 3 * BEATS, 0);
    checkOutput("ovf_level", fifo_level, 5'd16);
    checkOutput("ovf_drop_cnt", drop_cnt, 16'd1);
    idleCycles(2, 1);
    sendBeats(0, BEATS, 1);
    idleCycles(24, 1);
    checkOutput("ovf_pkt_cnt", pkt_cnt, 16'd5);

    // Enable removed mid-packet, re-enabled mid-group.
    $display("[TB] enable drop");
    sendBeats(0, 5, 1);
    applyStimulus(0, 0, 1, 2'd1, 32'h55, 1);
    idleCycles(1, 1);
    sendBeats(2, BEATS + 2, 1);
    idleCycles(12, 1);

    // Reset with a committed packet pending.
    $display("[TB] reset mid-stream");
    sendBeats(0, BEATS, 0);
    idleCycles(1, 0);
    applyStimulus(1, 1, 0, 2'd0, 32'd0, 0);
    #1;
    checkOutput("rst_valid", m_tvalid, 1'b0);
    checkOutput("rst_level", fifo_level, 5'd0);
    checkOutput("rst_pkt_cnt", pkt_cnt, 16'd0);
    idleCycles(1, 1);
    sendBeats(0, BEATS, 1);
    idleCycles(12, 1);

    // Sparse input with toggling ready.
    $display("[TB] sparse input");
    out_log.delete();
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, 2'((i + 2) % N), 32'(i), rdy);
      rdy = ~rdy;
      for (int k = 0; k < 3; k++) begin
        applyStimulus(0, 1, 0, 2'd0, 32'd0, rdy);
        rdy = ~rdy;
      end
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 0, 2'd0, 32'd0, rdy);
      rdy = ~rdy;
    end
    checkIndexPacket("sparse_data");

    // Random traffic with occasional ID errors, enable drops and resets.
    $display("[TB] random traffic");
    gen_id = 0;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 79) != 0);
      v  = ($urandom_range(0, 2) != 0);
      u  = ($urandom_range(0, 24) == 0) ? 2'($urandom) : 2'(gen_id % N);
      if (en && v) gen_id++;
      applyStimulus(($urandom_range(0, 499) == 0), en, v, u, $urandom,
                    ($urandom_range(0, 9) < 6));
    end
    idleCycles(20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
